// File: rtl/waveform_packetizer.sv
// waveform_packetizer
// Transmit-side framer: cuts a raw 32-bit sample stream into chunks and
// prefixes each chunk with a 5-word header (CMD, ID, IND, LEN, reserved word).
// Header words are driven from registered state; payload words pass straight
// through with zero latency so the sample source sees downstream ready directly.
module waveform_packetizer #(
  parameter logic [31:0] CMD_WORD      = 32'h5757_4441,
  parameter int unsigned CHUNK_WORDS   = 251,
  parameter logic [31:0] RESERVED_WORD = 32'h0000_0000
) (
  input  logic        axi_tclk,
  input  logic        axi_treset,
  input  logic        enable,
  input  logic [31:0] wfrm_len,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  input  logic        m_axis_tready,
  output logic [31:0] wf_id,
  output logic        busy,
  output logic        len_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  // Index of the final payload word in a full chunk.
  localparam logic [7:0] LP_LAST_PAY = 8'(CHUNK_WORDS - 1);

  state_t      r_state;
  logic [2:0]  r_hdr_cnt;
  logic [7:0]  r_pay_cnt;
  logic [31:0] r_word_cnt;
  logic [31:0] r_ind;
  logic [31:0] r_wf_id;
  logic [31:0] r_len_q;
  logic        r_len_err;

  logic [31:0] w_hdr_word;
  logic        w_last_pay;
  logic        w_pay_fire;

  assign w_last_pay = (r_pay_cnt == LP_LAST_PAY);
  assign w_pay_fire = s_axis_tvalid & m_axis_tready;

  assign m_axis_tkeep = 4'hf;
  assign wf_id        = r_wf_id;
  assign busy         = (r_state != ST_IDLE);
  assign len_err      = r_len_err;

  // Select the header word for the current header position.
  always_comb begin
    w_hdr_word = RESERVED_WORD;
    case (r_hdr_cnt)
      3'd0:    w_hdr_word = CMD_WORD;
      3'd1:    w_hdr_word = r_wf_id;
      3'd2:    w_hdr_word = r_ind;
      3'd3:    w_hdr_word = r_len_q;
      3'd4:    w_hdr_word = RESERVED_WORD;
      default: w_hdr_word = RESERVED_WORD;
    endcase
  end

  // Steer both stream interfaces by state; payload is a direct pass-through.
  always_comb begin
    m_axis_tdata  = 32'h0000_0000;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        m_axis_tdata  = 32'h0000_0000;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
      end
      ST_HDR: begin
        m_axis_tdata  = w_hdr_word;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
      end
      ST_PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast | w_last_pay;
        s_axis_tready = m_axis_tready;
      end
      default: begin
        m_axis_tdata  = 32'h0000_0000;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
      end
    endcase
  end

  // Framing FSM: header sequencing, chunk/word counting, waveform bookkeeping.
  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      r_state    <= ST_IDLE;
      r_hdr_cnt  <= 3'd0;
      r_pay_cnt  <= 8'd0;
      r_word_cnt <= 32'd0;
      r_ind      <= 32'd0;
      r_wf_id    <= 32'd0;
      r_len_q    <= 32'd0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Only the start of a new waveform is gated by enable; no sample
          // is consumed here, the first one is held for the payload phase.
          if (enable && s_axis_tvalid) begin
            r_len_q    <= wfrm_len;
            r_ind      <= 32'd0;
            r_word_cnt <= 32'd0;
            r_hdr_cnt  <= 3'd0;
            r_state    <= ST_HDR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (m_axis_tready) begin
            if (r_hdr_cnt == 3'd4) begin
              r_hdr_cnt <= 3'd0;
              r_pay_cnt <= 8'd0;
              r_state   <= ST_PAYLOAD;
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 3'd1;
            end
          end else begin
            r_hdr_cnt <= r_hdr_cnt;
          end
        end
        ST_PAYLOAD: begin
          if (w_pay_fire) begin
            r_pay_cnt  <= r_pay_cnt + 8'd1;
            r_word_cnt <= r_word_cnt + 32'd1;
            // End of waveform wins over chunk-full so a waveform that ends
            // exactly on a chunk boundary produces no empty trailing packet.
            if (s_axis_tlast) begin
              r_len_err <= ((r_word_cnt + 32'd1) != r_len_q);
              r_wf_id   <= r_wf_id + 32'd1;
              r_ind     <= 32'd0;
              r_state   <= ST_IDLE;
            end else if (w_last_pay) begin
              r_ind   <= r_ind + 32'd1;
              r_state <= ST_HDR;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end else begin
            r_state <= ST_PAYLOAD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_packetizer.sv
// Directed testbench for waveform_packetizer: builds the expected framed word
// stream for each waveform and compares every transferred word against it.
module tb_waveform_packetizer;

  localparam logic [31:0] CMD = 32'h5757_4441;

  logic        axi_tclk = 1'b0;
  logic        axi_treset;
  logic        enable;
  logic [31:0] wfrm_len;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tready;
  logic [31:0] wf_id;
  logic        busy;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_id;
  logic [31:0] q_data[$];
  logic        q_last[$];

  waveform_packetizer dut (
    .axi_tclk      (axi_tclk),
    .axi_treset    (axi_treset),
    .enable        (enable),
    .wfrm_len      (wfrm_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tready (m_axis_tready),
    .wf_id         (wf_id),
    .busy          (busy),
    .len_err       (len_err)
  );

  always #5 axi_tclk = ~axi_tclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one waveform and checks every output word; abort_at >= 0 applies
  // reset while output word number abort_at is on the bus.
  task automatic run_wave(input logic [31:0] len_decl, input int nsamp,
                          input logic [31:0] base, input int rdy_mode,
                          input bit rnd_valid, input int abort_at,
                          input int exp_pulses);
    int si = 0;
    int oi = 0;
    int cyc = 0;
    int pulses = 0;
    bit aborted = 1'b0;
    bit prev_hold = 1'b0;
    bit sfire_prev = 1'b1;
    bit mfire, sfire, v;
    logic [31:0] prev_data = 32'h0;
    q_data.delete();
    q_last.delete();
    for (int s = 0; s < nsamp; s++) begin
      if (s % 251 == 0) begin
        q_data.push_back(CMD);                  q_last.push_back(1'b0);
        q_data.push_back(exp_id);               q_last.push_back(1'b0);
        q_data.push_back(32'(s / 251));         q_last.push_back(1'b0);
        q_data.push_back(len_decl);             q_last.push_back(1'b0);
        q_data.push_back(32'h0);                q_last.push_back(1'b0);
      end
      q_data.push_back(base + 32'(s));
      q_last.push_back((s == nsamp - 1) || (s % 251 == 250));
    end
    wfrm_len = len_decl;
    while ((si < nsamp || oi < q_data.size()) && cyc < 20000 && !aborted) begin
      @(negedge axi_tclk);
      if (si < nsamp) begin
        if (rnd_valid) v = (s_axis_tvalid && !sfire_prev) ? 1'b1 : 1'($urandom_range(0, 1));
        else v = 1'b1;
      end else begin
        v = 1'b0;
      end
      s_axis_tvalid = v;
      s_axis_tdata  = base + 32'(si);
      s_axis_tlast  = (si == nsamp - 1);
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      #1;
      if (len_err) pulses++;
      if (prev_hold) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid) begin
        if (oi < q_data.size()) begin
          chk($sformatf("data[%0d]", oi), m_axis_tdata, q_data[oi]);
          chk($sformatf("last[%0d]", oi), 32'(m_axis_tlast), 32'(q_last[oi]));
        end else begin
          chk("extra_word", 32'(oi), 32'(q_data.size()));
        end
      end
      mfire = m_axis_tvalid & m_axis_tready;
      sfire = s_axis_tvalid & s_axis_tready;
      prev_hold = m_axis_tvalid & !m_axis_tready;
      prev_data = m_axis_tdata;
      sfire_prev = sfire;
      if (abort_at >= 0 && oi == abort_at) begin
        axi_treset = 1'b1;
        @(posedge axi_tclk);
        #1;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_tkeep", 32'(m_axis_tkeep), 32'hf);
        chk("rst_wf_id", wf_id, 32'd0);
        @(negedge axi_tclk);
        axi_treset = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        exp_id = 32'd0;
        aborted = 1'b1;
      end else begin
        @(posedge axi_tclk);
        if (mfire) oi++;
        if (sfire) si++;
        cyc++;
      end
    end
    if (!aborted) begin
      chk("words_done", 32'(oi), 32'(q_data.size()));
      chk("samples_done", 32'(si), 32'(nsamp));
      @(negedge axi_tclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      if (len_err) pulses++;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      @(negedge axi_tclk);
      #1;
      if (len_err) pulses++;
      chk("len_err_pulses", 32'(pulses), 32'(exp_pulses));
      exp_id = exp_id + 32'd1;
      chk("wf_id_after", wf_id, exp_id);
    end
  endtask

  initial begin
    axi_treset    = 1'b1;
    enable        = 1'b0;
    wfrm_len      = 32'd0;
    s_axis_tdata  = 32'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    exp_id        = 32'd0;
    repeat (3) @(posedge axi_tclk);
    #1;
    chk("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_m_tlast", 32'(m_axis_tlast), 32'd0);
    chk("reset_s_tready", 32'(s_axis_tready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_len_err", 32'(len_err), 32'd0);
    chk("reset_tkeep", 32'(m_axis_tkeep), 32'hf);
    chk("reset_wf_id", wf_id, 32'd0);
    @(negedge axi_tclk);
    axi_treset = 1'b0;

    // enable low: a pending sample must not start a waveform
    s_axis_tvalid = 1'b1;
    repeat (4) @(posedge axi_tclk);
    #1;
    chk("disabled_busy", 32'(busy), 32'd0);
    chk("disabled_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("disabled_s_tready", 32'(s_axis_tready), 32'd0);
    @(negedge axi_tclk);
    s_axis_tvalid = 1'b0;
    enable = 1'b1;

    // nominal 4-chunk waveform
    run_wave(32'd1004, 1004, 32'h0000_0000, 0, 1'b0, -1, 0);
    // short single-chunk waveform
    run_wave(32'd10, 10, 32'h0001_0000, 0, 1'b0, -1, 0);
    // waveform ending exactly on a chunk boundary
    run_wave(32'd251, 251, 32'h0002_0000, 0, 1'b0, -1, 0);
    // back-pressure with random source valid
    run_wave(32'd1004, 1004, 32'h0003_0000, 1, 1'b1, -1, 0);
    // declared length larger than sent samples
    run_wave(32'd20, 12, 32'h0004_0000, 0, 1'b0, -1, 1);
    // following waveform carries the next ID
    run_wave(32'd10, 10, 32'h0005_0000, 0, 1'b0, -1, 0);
    // reset during payload word 100 of chunk 1
    run_wave(32'd1004, 1004, 32'h0006_0000, 0, 1'b0, 360, 0);
    // first waveform after reset restarts at ID 0
    run_wave(32'd10, 10, 32'h0007_0000, 0, 1'b0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
